// File: rtl/hazard_pkg.sv
// Shared encodings and defaults for the D-stage hazard controller.
// Imported by hazard_unit and md_busy_timer.
package hazard_pkg;

    // Multiply/divide operation selector, valid alongside MDStart
    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_op_e;

    // Default MD unit latencies
    localparam int unsigned DEF_MUL_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES = 10;

    // Default width of Tuse/Tnew values
    localparam int unsigned DEF_TW = 3;

    // Larger of two latencies, used to size the busy counter
    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Busy countdown for the multi-cycle multiply/divide unit.
// Loads on a start while idle, then counts down to zero.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic MDStart,
    input  logic MDOp,
    output logic MDBusy
);

    localparam int unsigned MAXC = max_u(MUL_CYCLES, DIV_CYCLES);
    localparam int unsigned CW   = $clog2(MAXC + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] load_val;
    logic          idle;

    assign idle     = (count_q == '0);
    assign load_val = (md_op_e'(MDOp) == MD_DIV) ? CW'(DIV_CYCLES)
                                                 : CW'(MUL_CYCLES);

    // Next count: a start while busy is ignored and the countdown continues
    always_comb begin
        count_d = count_q;
        if (MDStart && idle) begin
            count_d = load_val;
        end else if (!idle) begin
            count_d = count_q - CW'(1);
        end
    end

    // Counter register, cleared by reset with no residual busy
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign MDBusy = !idle;

endmodule

// File: rtl/hazard_unit.sv
// D-stage hazard/stall controller: GPR Tuse/Tnew, eret/EPC and MD busy stalls.
// Define HAZARD_PERF_EN to build the saturating stall-cycle counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned NSTAGE     = 2,
    parameter int unsigned TW         = DEF_TW,
    parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [TW-1:0]         TUseRs,
    input  logic [4:0]            Rs,
    input  logic [TW-1:0]         TUseRt,
    input  logic [4:0]            Rt,
    input  logic                  DUseMD,
    input  logic                  DEret,
    input  logic [NSTAGE*TW-1:0]  StageTNew,
    input  logic [NSTAGE*5-1:0]   StageRegDst,
    input  logic [NSTAGE-1:0]     StageWriteRegEn,
    input  logic [NSTAGE-1:0]     StageWriteEPC,
    input  logic                  MDStart,
    input  logic                  MDOp,
    output logic                  Stall,
    output logic                  MDBusy,
    output logic [CNT_W-1:0]      StallCount
);

    logic [NSTAGE-1:0] rs_haz;
    logic [NSTAGE-1:0] rt_haz;
    logic              gpr_stall;
    logic              eret_stall;
    logic              md_stall;

    // Per-stage comparison; $0 never produces a hazard
    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        logic [TW-1:0] tnew;
        logic [4:0]    dst;

        assign tnew = StageTNew[i*TW +: TW];
        assign dst  = StageRegDst[i*5 +: 5];

        assign rs_haz[i] = StageWriteRegEn[i] && (dst == Rs)
                        && (Rs != 5'd0) && (TUseRs < tnew);
        assign rt_haz[i] = StageWriteRegEn[i] && (dst == Rt)
                        && (Rt != 5'd0) && (TUseRt < tnew);
    end

    md_busy_timer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_timer (
        .clk     (clk),
        .reset   (reset),
        .MDStart (MDStart),
        .MDOp    (MDOp),
        .MDBusy  (MDBusy)
    );

    // Combine all stall sources; no registered delay on Stall
    always_comb begin
        gpr_stall  = (|rs_haz) || (|rt_haz);
        eret_stall = DEret && (|StageWriteEPC);
        md_stall   = DUseMD && (MDBusy || MDStart);
        Stall      = gpr_stall || eret_stall || md_stall;
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Saturating count of stalled cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`else
    assign StallCount = '0;
`endif

endmodule
